// File: rtl/multi_delay_timer_pkg.sv
// Shared types and constants for the multi-channel delay/tick generator.
package multi_delay_timer_pkg;

   typedef enum logic {StIdle, StRun} state_e;
   typedef enum logic {ModePeriodic, ModeOneshot} mode_e;

   localparam int unsigned DefaultN = 12500;

endpackage

// File: rtl/delay_chan.sv
// One timer channel: IDLE/RUN FSM, cycle counter, active and pending period/mode,
// sticky retrigger flag and a counter-overrun invariant monitor.
module delay_chan
   import multi_delay_timer_pkg::*;
#(
   parameter int unsigned CBITS     = 14,
   parameter int unsigned DEFAULT_N = DefaultN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we_i,
   input  logic [CBITS-1:0] cfg_period_i,
   input  logic             cfg_oneshot_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             flag_clr_i,
   output logic             tick_o,
   output logic             busy_o,
   output logic             retrig_o,
   output logic             err_o
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d, pend_mode_q, pend_mode_d;
   logic [CBITS-1:0] cnt_q, cnt_d, per_q, per_d, pend_per_q, pend_per_d;
   logic             pend_v_q, pend_v_d;
   logic             tick_q, tick_d, retrig_q, retrig_d, err_q, err_d;

   mode_e            cfg_mode, eff_mode;
   logic [CBITS-1:0] eff_per;
   logic             eff_v, apply, retrig_set;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      per_d       = per_q;
      pend_per_d  = pend_per_q;
      pend_mode_d = pend_mode_q;
      pend_v_d    = pend_v_q;
      tick_d      = 1'b0;
      apply       = 1'b0;
      retrig_set  = 1'b0;
      cfg_mode    = cfg_oneshot_i ? ModeOneshot : ModePeriodic;
      // A write landing on the reload/stop edge takes effect on that same edge.
      eff_v       = cfg_we_i | pend_v_q;
      eff_per     = cfg_we_i ? cfg_period_i : pend_per_q;
      eff_mode    = cfg_we_i ? cfg_mode : pend_mode_q;

      unique case (state_q)
         StIdle: begin
            if (cfg_we_i) begin
               per_d  = cfg_period_i;
               mode_d = cfg_mode;
            end
            if (start_i && !stop_i) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (stop_i) begin
               state_d = StIdle;
               cnt_d   = '0;
               apply   = 1'b1;
            end else if (start_i) begin
               cnt_d      = '0;
               retrig_set = 1'b1;
            end else if (cnt_q == per_q) begin
               tick_d = 1'b1;
               cnt_d  = '0;
               apply  = 1'b1;
               if (mode_q == ModeOneshot) state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end

            if (apply) begin
               if (eff_v) begin
                  per_d    = eff_per;
                  mode_d   = eff_mode;
                  pend_v_d = 1'b0;
               end
            end else if (cfg_we_i) begin
               pend_per_d  = cfg_period_i;
               pend_mode_d = cfg_mode;
               pend_v_d    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      retrig_d = retrig_set | (retrig_q & ~flag_clr_i);
      err_d    = (cnt_q > per_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         mode_q      <= ModePeriodic;
         pend_mode_q <= ModePeriodic;
         cnt_q       <= '0;
         per_q       <= CBITS'(DEFAULT_N);
         pend_per_q  <= CBITS'(DEFAULT_N);
         pend_v_q    <= 1'b0;
         tick_q      <= 1'b0;
         retrig_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pend_mode_q <= pend_mode_d;
         cnt_q       <= cnt_d;
         per_q       <= per_d;
         pend_per_q  <= pend_per_d;
         pend_v_q    <= pend_v_d;
         tick_q      <= tick_d;
         retrig_q    <= retrig_d;
         err_q       <= err_d;
      end
   end

   assign tick_o   = tick_q;
   assign busy_o   = (state_q == StRun);
   assign retrig_o = retrig_q;
   assign err_o    = err_q;

endmodule

// File: rtl/multi_delay_timer.sv
// NCH independent programmable delay/tick channels sharing one config write port.
module multi_delay_timer
   import multi_delay_timer_pkg::*;
#(
   parameter int unsigned NCH       = 4,
   parameter int unsigned CBITS     = 14,
   parameter int unsigned DEFAULT_N = DefaultN,
   localparam int unsigned ChW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we_i,
   input  logic [ChW-1:0]   cfg_ch_i,
   input  logic [CBITS-1:0] cfg_period_i,
   input  logic             cfg_oneshot_i,
   input  logic [NCH-1:0]   start_i,
   input  logic [NCH-1:0]   stop_i,
   input  logic [NCH-1:0]   flag_clr_i,
   output logic [NCH-1:0]   tick_o,
   output logic [NCH-1:0]   busy_o,
   output logic [NCH-1:0]   retrig_o,
   output logic [NCH-1:0]   err_o
);

   logic [NCH-1:0] ch_we;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      // Indices at or above NCH match no channel, so such writes are dropped.
      assign ch_we[i] = cfg_we_i && (cfg_ch_i == ChW'(i));

      delay_chan #(
         .CBITS     (CBITS),
         .DEFAULT_N (DEFAULT_N)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .cfg_we_i      (ch_we[i]),
         .cfg_period_i  (cfg_period_i),
         .cfg_oneshot_i (cfg_oneshot_i),
         .start_i       (start_i[i]),
         .stop_i        (stop_i[i]),
         .flag_clr_i    (flag_clr_i[i]),
         .tick_o        (tick_o[i]),
         .busy_o        (busy_o[i]),
         .retrig_o      (retrig_o[i]),
         .err_o         (err_o[i])
      );
   end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer: deadline-based reference model checked every cycle,
// plus hand-computed literal expectations from the directed scenarios.
module tb_multi_delay_timer;

   localparam int NCH  = 4;
   localparam int DEFN = 12500;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [13:0] cfg_period = '0;
   logic        cfg_oneshot = 1'b0;
   logic [3:0]  start = '0, stop = '0, flag_clr = '0;
   logic [3:0]  tick, busy, retrig, err;

   multi_delay_timer dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_we_i      (cfg_we),
      .cfg_ch_i      (cfg_ch),
      .cfg_period_i  (cfg_period),
      .cfg_oneshot_i (cfg_oneshot),
      .start_i       (start),
      .stop_i        (stop),
      .flag_clr_i    (flag_clr),
      .tick_o        (tick),
      .busy_o        (busy),
      .retrig_o      (retrig),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   int     n_chk = 0;
   int     n_pass = 0;
   longint cyc = 0;
   longint base = 0;

   // Model: each running channel holds the absolute edge index of its next expiry.
   bit     m_run [NCH];
   longint m_due [NCH];
   int     m_per [NCH];
   bit     m_osh [NCH];
   bit     m_pv  [NCH];
   int     m_pp  [NCH];
   bit     m_po  [NCH];
   bit     m_rt  [NCH];
   bit     m_tk  [NCH];

   task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
   endtask

   always @(posedge clk) begin
      logic [3:0] e_tick, e_busy, e_rt;
      bit we, set_rt, applied, ended;
      cyc = cyc + 1;
      for (int c = 0; c < NCH; c++) begin
         m_tk[c] = 1'b0;
         if (rst) begin
            m_run[c] = 0; m_per[c] = DEFN; m_osh[c] = 0; m_pv[c] = 0; m_rt[c] = 0;
         end else begin
            we = cfg_we && (int'(cfg_ch) == c);
            set_rt = 0; applied = 0; ended = 0;
            if (m_run[c]) begin
               if (stop[c]) begin
                  m_run[c] = 0; applied = 1;
               end else if (start[c]) begin
                  m_due[c] = cyc + m_per[c] + 1; set_rt = 1;
               end else if (cyc == m_due[c]) begin
                  m_tk[c] = 1; applied = 1; ended = m_osh[c];
               end
               if (applied) begin
                  if (we) begin
                     m_per[c] = int'(cfg_period); m_osh[c] = cfg_oneshot;
                  end else if (m_pv[c]) begin
                     m_per[c] = m_pp[c]; m_osh[c] = m_po[c];
                  end
                  m_pv[c] = 0;
                  if (m_tk[c]) begin
                     if (ended) m_run[c] = 0;
                     else m_due[c] = cyc + m_per[c] + 1;
                  end
               end else if (we) begin
                  m_pp[c] = int'(cfg_period); m_po[c] = cfg_oneshot; m_pv[c] = 1;
               end
            end else begin
               if (we) begin
                  m_per[c] = int'(cfg_period); m_osh[c] = cfg_oneshot;
               end
               if (start[c] && !stop[c]) begin
                  m_run[c] = 1; m_due[c] = cyc + m_per[c] + 1;
               end
            end
            m_rt[c] = set_rt | (m_rt[c] & !flag_clr[c]);
         end
      end
      for (int c = 0; c < NCH; c++) begin
         e_tick[c] = m_tk[c]; e_busy[c] = m_run[c]; e_rt[c] = m_rt[c];
      end
      #1;
      chk("tick", tick, e_tick);
      chk("busy", busy, e_busy);
      chk("retrig", retrig, e_rt);
      chk("err", err, 4'h0);
   end

   // Advance to local cycle c (outputs of edge base+c visible); pulses last one cycle.
   task automatic goto(input longint c);
      while (cyc < base + c) begin
         @(posedge clk);
         #2;
         cfg_we = 0; start = '0; stop = '0; flag_clr = '0;
      end
   endtask

   task automatic wr(input int ch, input int per, input bit osh);
      cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 14'(per); cfg_oneshot = osh;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at time %0t", $time);
      $fatal(1);
   end

   initial begin
      base = 0;
      goto(3);
      rst = 0;

      // Idle after reset.
      base = cyc;
      goto(200);
      chk("idle_tick", tick, 4'h0);
      chk("idle_busy", busy, 4'h0);
      chk("idle_retrig", retrig, 4'h0);

      // Ch1 one-shot N=5 with write+start together; ch0 periodic N=3.
      base = cyc;
      wr(1, 5, 1); start[1] = 1;
      goto(6);  chk("c1_busy6", {3'b0, busy[1]}, 4'h1);
      goto(7);  chk("c1_tick7", {3'b0, tick[1]}, 4'h1);
                chk("c1_busy7", {3'b0, busy[1]}, 4'h0);
      goto(8);  chk("c1_tick8", {3'b0, tick[1]}, 4'h0);
                wr(0, 3, 0);
      goto(10); start[0] = 1;
                chk("c0_busy10", {3'b0, busy[0]}, 4'h0);
      goto(11); chk("c0_busy11", {3'b0, busy[0]}, 4'h1);
      goto(14); chk("c0_tick14", {3'b0, tick[0]}, 4'h0);
      goto(15); chk("c0_tick15", {3'b0, tick[0]}, 4'h1);
      goto(19); chk("c0_tick19", {3'b0, tick[0]}, 4'h1);
      goto(23); chk("c0_tick23", {3'b0, tick[0]}, 4'h1);
      goto(30); stop[0] = 1;
      goto(32); chk("c0_busy32", {3'b0, busy[0]}, 4'h0);

      // Ch2 N=10, pending writes mid-interval (second replaces first).
      base = cyc;
      wr(2, 10, 0);
      goto(1);  start[2] = 1;
      goto(5);  wr(2, 7, 0);
      goto(6);  wr(2, 2, 0);
      goto(12); chk("c2_tick12", {3'b0, tick[2]}, 4'h0);
      goto(13); chk("c2_tick13", {3'b0, tick[2]}, 4'h1);
      goto(14); chk("c2_tick14", {3'b0, tick[2]}, 4'h0);
      goto(16); chk("c2_tick16", {3'b0, tick[2]}, 4'h1);
      goto(19); chk("c2_tick19", {3'b0, tick[2]}, 4'h1);
      goto(25); stop[2] = 1;

      // Ch3 retrigger/flag handling; ch0 N=0 periodic.
      base = cyc;
      wr(3, 8, 0);
      goto(1);  start[3] = 1;
      goto(2);  wr(0, 0, 0);
      goto(3);  start[0] = 1;
      goto(4);  chk("c0_n0_tick4", {3'b0, tick[0]}, 4'h0);
      goto(5);  chk("c0_n0_tick5", {3'b0, tick[0]}, 4'h1);
      goto(6);  chk("c0_n0_tick6", {3'b0, tick[0]}, 4'h1);
                chk("c3_rt6", {3'b0, retrig[3]}, 4'h0);
                start[3] = 1;
      goto(7);  chk("c3_rt7", {3'b0, retrig[3]}, 4'h1);
      goto(10); stop[0] = 1;
      goto(11); chk("c0_stop_tick11", {3'b0, tick[0]}, 4'h0);
                chk("c3_tick11", {3'b0, tick[3]}, 4'h0);
      goto(15); chk("c3_tick15", {3'b0, tick[3]}, 4'h0);
      goto(16); chk("c3_tick16", {3'b0, tick[3]}, 4'h1);
      goto(20); flag_clr[3] = 1;
      goto(21); chk("c3_rt21", {3'b0, retrig[3]}, 4'h0);
      goto(22); start[3] = 1; flag_clr[3] = 1;
      goto(23); chk("c3_rt23", {3'b0, retrig[3]}, 4'h1);
      goto(25); start[3] = 1; stop[3] = 1;
      goto(26); chk("c3_busy26", {3'b0, busy[3]}, 4'h0);
                chk("c3_rt26", {3'b0, retrig[3]}, 4'h1);
      goto(40); chk("c3_tick40", {3'b0, tick[3]}, 4'h0);

      // All channels at the default period, reset mid-run, then restart.
      base = cyc;
      wr(0, DEFN, 0);
      goto(1);  wr(1, DEFN, 0);
      goto(2);  wr(2, DEFN, 0);
      goto(3);  wr(3, DEFN, 0);
      goto(5);  start = 4'hF;
      goto(6006); chk("def_busy", busy, 4'hF);
                  rst = 1;
      goto(6007); rst = 0;
                  chk("rst_busy", busy, 4'h0);
                  chk("rst_tick", tick, 4'h0);
                  chk("rst_retrig", retrig, 4'h0);
      goto(6010); start = 4'hF;
      goto(18511); chk("def_tick_early", tick, 4'h0);
      goto(18512); chk("def_tick", tick, 4'hF);
      goto(18514); stop = 4'hF;
      goto(18520); chk("end_busy", busy, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_delay_timer.md
Name: multi_delay_timer

Overview:
- Multi-channel programmable delay/tick generator. Successor to the team's single fixed-N delay counter.
- NCH independent channels, each with a runtime-programmable period, periodic or one-shot mode, start/stop control and retrigger detection.
- Carries an invariant error flag per channel for formal checks (never-asserts property).
- Sits between the control register block and the downstream sequencers that consume tick pulses.

Parameters:
- NCH, 4, number of independent channels (1..16).
- CBITS, 14, counter and period width in bits.
- DEFAULT_N, 12500, reset value of every channel's period; must fit in CBITS.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  max(1,$clog2(NCH))  channel index for the write; out-of-range index ignores the write.
- cfg_period  in  CBITS  period value N.
- cfg_oneshot  in  1  mode: 0 = periodic, 1 = one-shot.
- start  in  NCH  per-channel start pulse.
- stop  in  NCH  per-channel stop pulse.
- flag_clr  in  NCH  clears the sticky retrig flag.
- tick  out  NCH  registered one-cycle pulse at period expiry.
- busy  out  NCH  channel in RUN.
- retrig  out  NCH  sticky: start was received while in RUN.
- err  out  NCH  invariant violation: cnt > active period. Must never assert.

Behaviour:
- Reset values (rst high at a clock edge): state IDLE, cnt 0, active period and pending period DEFAULT_N, mode periodic, no pending update. All outputs 0. rst overrides every other input.
- Per-channel FSM, IDLE/RUN:
  - IDLE + start: go to RUN, cnt <= 0.
  - IDLE + stop: no effect.
  - RUN, each cycle: if cnt == active period, then tick <= 1 next cycle and cnt <= 0. Periodic mode stays in RUN; one-shot mode goes to IDLE. Otherwise cnt <= cnt + 1.
  - RUN + stop: go to IDLE, cnt <= 0, no tick that cycle even if expiry coincides.
  - RUN + start (retrigger): cnt <= 0, stay in RUN, retrig <= 1. Expiry in the same cycle is suppressed.
  - start and stop in the same cycle: stop wins; retrig is unchanged.
- Latency:
  - Start accepted at edge E0. The first tick is high during the cycle after edge E0+N+1.
  - Periodic ticks are spaced N+1 cycles apart.
  - N = 0 in periodic mode: tick high every cycle from the second cycle after start onward.
- Config writes:
  - Channel in IDLE: period and mode update at the next edge.
  - Channel in RUN: the value is held as pending and applied at the next expiry (cnt reload) or stop, whichever comes first. The running interval is never shortened or stretched mid-flight.
  - A second write before application replaces the pending value.
  - A write and a start in the same cycle on an IDLE channel: the new config is used for that run.
- retrig is sticky. flag_clr clears it; a retrigger in the same cycle as flag_clr wins (flag stays 1).
- busy = (state == RUN), registered alongside state.
- err[ch] = (cnt > active period), registered. The design guarantees 0; it is a formal/sim observation point.
- Arithmetic: cnt is CBITS wide. Wrap-around is unreachable because reload occurs at cnt == period ≤ 2^CBITS−1.

Decomposition:
- Package multi_delay_timer_pkg:
  - state enum {IDLE, RUN};
  - mode enum {PERIODIC, ONESHOT};
  - constant DEFAULT_N.
- One sub-module, delay_chan: a single channel with its own FSM, counter, active/pending config, tick, busy, retrig and err.
- The top generates NCH instances and decodes cfg_ch into per-channel write enables.

Test Plan:
- Reset then idle 200 cycles, no start → tick, busy, retrig, err all 0; err == 0 for the whole run.
- Ch0: period 3, periodic, start at cycle 10 → tick high at cycles 15, 19, 23; busy high from cycle 11.
- Ch1: period 5, one-shot, start at cycle 0 → a single tick at cycle 7; busy drops at cycle 7; no further ticks.
- Ch2: period 10 running. Write period 2 mid-interval at cnt = 4 → current interval still 11 cycles; following intervals 3 cycles.
- Ch3: start at cycle 0, period 8, start again at cycle 5 → retrig = 1, first tick at cycle 15. flag_clr → retrig = 0. Start and stop in the same cycle → goes IDLE, no tick.
- All channels at DEFAULT_N = 12500, periodic, plus rst asserted mid-run at cnt = 6000 → next cycle all outputs 0 and cnt 0; after restart the tick is 12502 cycles after the start edge.
